// File: rtl/cfs_ctrl_cfg_sync_if.sv
// cfs_ctrl_cfg_sync_if: register-block to config-sequencer update request bus
interface cfs_ctrl_cfg_sync_if #(
  parameter int ALGN_DATA_WIDTH = 32
);
  localparam int N = ALGN_DATA_WIDTH / 8;
  localparam int OW = ALGN_DATA_WIDTH <= 8 ? 1 : $clog2(N);
  localparam int SW = $clog2(N) + 1;
  logic wr_valid;
  logic [OW-1:0] wr_offset;
  logic [SW-1:0] wr_size;
  logic wr_ready;
  modport master (output wr_valid, output wr_offset, output wr_size, input wr_ready);
  modport slave (input wr_valid, input wr_offset, input wr_size, output wr_ready);
endinterface

// File: rtl/cfs_ctrl_cfg_sync.sv
// cfs_ctrl_cfg_sync: checks offset/size updates and applies them only after the aligner has drained
module cfs_ctrl_cfg_sync #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int DRAIN_TIMEOUT = 256,
  localparam int N = ALGN_DATA_WIDTH / 8,
  localparam int OW = ALGN_DATA_WIDTH <= 8 ? 1 : $clog2(N),
  localparam int SW = $clog2(N) + 1,
  localparam int CW = $clog2(DRAIN_TIMEOUT)
) (
  input  logic clk,
  input  logic reset_n,
  cfs_ctrl_cfg_sync_if.slave cfg,
  input  logic ctrl_idle,
  output logic hold_pop,
  output logic [OW-1:0] ctrl_offset,
  output logic [SW-1:0] ctrl_size,
  output logic cfg_done,
  output logic cfg_err,
  output logic cfg_timeout,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, DRAIN, APPLY, RELEASE} state_t;
  state_t state, state_n;
  logic ready;
  logic idle_q;
  logic [CW-1:0] cnt;
  logic [OW-1:0] shadow_offset;
  logic [SW-1:0] shadow_size;
  logic [SW:0] off_x, sz_x, n_x, sz_div;
  logic legal, same, accept, done_n, err_n, timeout_n;
  assign cfg.wr_ready = ready;
  assign accept = cfg.wr_valid && ready;
  assign off_x = (SW+1)'(cfg.wr_offset);
  assign sz_x = {1'b0, cfg.wr_size};
  assign n_x = (SW+1)'(N);
  assign sz_div = sz_x == '0 ? (SW+1)'(1) : sz_x;
  assign legal = (sz_x != '0) && (off_x + sz_x <= n_x) && ((n_x + off_x) % sz_div == '0);
  assign same = cfg.wr_offset == ctrl_offset && cfg.wr_size == ctrl_size;
  // next state and single-cycle status pulses
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    err_n = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        err_n = accept && !legal;
        done_n = accept && legal && same;
        state_n = accept && legal && !same ? DRAIN : IDLE;
      end
      DRAIN: begin
        timeout_n = !(ctrl_idle && idle_q) && cnt == CW'(DRAIN_TIMEOUT - 1);
        state_n = ctrl_idle && idle_q ? APPLY : timeout_n ? IDLE : DRAIN;
      end
      APPLY: begin
        done_n = 1'b1;
        state_n = RELEASE;
      end
      RELEASE: state_n = IDLE;
    endcase
  end
  // state, registered outputs, shadow config and drain bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ready <= 1'b1;
      hold_pop <= 1'b0;
      busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      cfg_timeout <= 1'b0;
      ctrl_offset <= '0;
      ctrl_size <= SW'(1);
      shadow_offset <= '0;
      shadow_size <= '0;
      cnt <= '0;
      idle_q <= 1'b0;
    end else begin
      state <= state_n;
      ready <= state_n == IDLE;
      hold_pop <= state_n != IDLE;
      busy <= state_n != IDLE;
      cfg_done <= done_n;
      cfg_err <= err_n;
      cfg_timeout <= timeout_n;
      cnt <= state == DRAIN ? cnt + 1'b1 : '0;
      idle_q <= state == DRAIN && ctrl_idle;
      shadow_offset <= state == IDLE && state_n == DRAIN ? cfg.wr_offset : timeout_n ? '0 : shadow_offset;
      shadow_size <= state == IDLE && state_n == DRAIN ? cfg.wr_size : timeout_n ? '0 : shadow_size;
      if (state == APPLY) begin
        ctrl_offset <= shadow_offset;
        ctrl_size <= shadow_size;
      end
    end
  end
endmodule

// File: tb/tb_cfs_ctrl_cfg_sync.sv
// tb_cfs_ctrl_cfg_sync: directed and randomized checks of the config sequencer against a request-level model
module tb_cfs_ctrl_cfg_sync;
  localparam int DW = 32;
  localparam int T = 8;
  localparam int N = DW / 8;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ctrl_idle = 1'b0;
  logic hold_pop, cfg_done, cfg_err, cfg_timeout, busy;
  logic [1:0] ctrl_offset;
  logic [2:0] ctrl_size;
  logic [1:0] cur_off = 2'd0;
  logic [2:0] cur_sz = 3'd1;
  int tests = 0;
  int fails = 0;
  cfs_ctrl_cfg_sync_if #(.ALGN_DATA_WIDTH(DW)) cfg_if ();
  cfs_ctrl_cfg_sync #(.ALGN_DATA_WIDTH(DW), .DRAIN_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .cfg(cfg_if), .ctrl_idle(ctrl_idle), .hold_pop(hold_pop),
    .ctrl_offset(ctrl_offset), .ctrl_size(ctrl_size), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cfg_timeout(cfg_timeout), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] ev(bit r, bit h, bit d, bit e, bit t);
    return {r, h, h, d, e, t, cur_off, cur_sz};
  endfunction
  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    got = {cfg_if.wr_ready, hold_pop, busy, cfg_done, cfg_err, cfg_timeout, ctrl_offset, ctrl_size};
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b (rdy,hold,busy,done,err,to,off,size)", tag, got, exp);
    end
  endtask
  // one request: pv[i] is ctrl_idle during the i-th drain cycle; keep holds a second request o2/s2 on the bus
  task automatic req(input logic [1:0] o, input logic [2:0] s, input logic [7:0] pv,
                     input bit keep, input logic [1:0] o2, input logic [2:0] s2);
    int oi, si, j, last;
    bit legal, same;
    oi = o;
    si = s;
    legal = si != 0 ? (oi + si <= N && (N + oi) % si == 0) : 1'b0;
    same = legal && o == cur_off && s == cur_sz;
    j = 0;
    if (legal && !same)
      for (int x = 2; x <= T; x++)
        if (pv[x-1] && pv[x-2]) begin
          j = x;
          break;
        end
    @(negedge clk);
    cfg_if.wr_valid = 1'b1;
    cfg_if.wr_offset = o;
    cfg_if.wr_size = s;
    @(posedge clk);
    #1;
    if (keep) begin
      cfg_if.wr_offset = o2;
      cfg_if.wr_size = s2;
    end else cfg_if.wr_valid = 1'b0;
    if (!legal || same) begin
      chk(legal ? "same_done" : "illegal_err", legal ? ev(1, 0, 1, 0, 0) : ev(1, 0, 0, 1, 0));
      @(posedge clk);
      #1;
      chk("pulse_end", ev(1, 0, 0, 0, 0));
      return;
    end
    chk("accept", ev(0, 1, 0, 0, 0));
    ctrl_idle = pv[0];
    last = j != 0 ? j + 2 : T + 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      if (j != 0) begin
        if (k <= j) chk("drain_apply", ev(0, 1, 0, 0, 0));
        else if (k == j + 1) begin
          cur_off = o;
          cur_sz = s;
          chk("release", ev(0, 1, 1, 0, 0));
        end else chk("back_idle", ev(1, 0, 0, 0, 0));
      end else begin
        if (k < T) chk("drain", ev(0, 1, 0, 0, 0));
        else if (k == T) chk("timeout", ev(1, 0, 0, 0, 1));
        else chk("timeout_end", ev(1, 0, 0, 0, 0));
      end
      ctrl_idle = k < 8 ? pv[k] : 1'b1;
    end
  endtask
  initial begin
    logic [1:0] ro;
    logic [2:0] rs;
    logic [7:0] rp;
    int m;
    cfg_if.wr_valid = 1'b0;
    cfg_if.wr_offset = '0;
    cfg_if.wr_size = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset", ev(1, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    req(2'd0, 3'd4, 8'hFF, 0, '0, '0);
    req(2'd0, 3'd3, 8'hFF, 0, '0, '0);
    req(2'd1, 3'd2, 8'hFF, 0, '0, '0);
    req(2'd0, 3'd0, 8'hFF, 0, '0, '0);
    req(2'd2, 3'd2, 8'hFF, 0, '0, '0);
    req(2'd2, 3'd2, 8'hFF, 0, '0, '0);
    req(2'd0, 3'd4, 8'b1110_0000, 1, 2'd0, 3'd1);
    req(2'd0, 3'd1, 8'hFF, 0, '0, '0);
    req(2'd1, 3'd1, 8'h00, 0, '0, '0);
    req(2'd1, 3'd1, 8'b1000_0000, 0, '0, '0);
    req(2'd1, 3'd1, 8'b1100_0000, 0, '0, '0);
    @(negedge clk);
    cfg_if.wr_valid = 1'b1;
    cfg_if.wr_offset = 2'd2;
    cfg_if.wr_size = 3'd2;
    @(posedge clk);
    #1 cfg_if.wr_valid = 1'b0;
    ctrl_idle = 1'b0;
    @(posedge clk);
    #1 chk("mid_drain", ev(0, 1, 0, 0, 0));
    reset_n = 1'b0;
    cur_off = 2'd0;
    cur_sz = 3'd1;
    #1 chk("async_reset", ev(1, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      rs = $urandom_range(0, 1) != 0 ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      m = $urandom_range(0, 3);
      rp = m == 0 ? 8'hFF : m == 1 ? 8'($urandom) : m == 2 ? 8'(8'hFF << $urandom_range(0, 7)) : 8'h00;
      ctrl_idle = 1'($urandom);
      req(ro, rs, rp, 0, '0, '0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
